rr_arbiter_4: RTL and testbench
===============================

# rr_arbiter_4

Four-requester round-robin arbiter that shares a single downstream resource (e.g. the 4-to-2 encoded datapath lane) between requesters 0-3. It issues a registered one-hot grant plus the same winner as a 2-bit encoded index, compatible with the team's 4:2 encoder convention (bit 0 → 00 … bit 3 → 11). Grants are held until the owner drops its request. An optional hold-limit timer forces release. The block sits between the requesting agents and the shared-resource mux select.

## Interface
- `MAX_HOLD`, default 8: max consecutive grant cycles per ownership when the timeout feature is compiled in; legal range 2-255.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 4: request vector; bit i high = requester i wants the resource; held high for the whole transaction.
- `gnt` output 4: registered one-hot grant; all-zero when nobody owns the resource.
- `gnt_idx` output 2: encoded index of the current owner; bit i of `gnt` → binary i; 00 when `gnt_valid`=0.
- `gnt_valid` output 1: high while any grant is active; equals OR of `gnt`.
- `gnt_expired` output 1: one-cycle pulse when a grant is forcibly revoked by the hold timer.

## Operation
- State machine:
  - `IDLE`: no owner.
  - `BUSY`: owner recorded in `gnt_idx`.
- Priority pointer `ptr` (2 bits) marks the highest-priority requester for the next arbitration. The search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3` mod 4.
- `IDLE`:
  - If `req` ≠ 0: the first set bit in search order wins. Go to `BUSY`, set `gnt`/`gnt_idx`/`gnt_valid` for the winner, set `ptr` = winner+1 mod 4 (wraps 3→0), and clear `hold_cnt` to 0.
  - If `req` = 0: stay in `IDLE`; outputs stay zero; `ptr` unchanged.
- `BUSY`:
  - If `req[gnt_idx]` = 0: go to `IDLE` and clear all grant outputs on that edge. There is no re-arbitration on the same edge, so there is always at least one idle cycle between owners.
  - Otherwise: hold the grant and increment `hold_cnt` (saturating).
- Requests from non-owners while `BUSY` are ignored; they are serviced in later arbitrations.
- Reset value of every output and internal register:
  - `gnt`=0000, `gnt_idx`=00, `gnt_valid`=0, `gnt_expired`=0.
  - `ptr`=0, state `IDLE`, `hold_cnt`=0.
- Reset mid-grant drops the grant on the reset edge. Priority restarts from requester 0.

## Timing
- Arbitration latency: `req` sampled high on edge N while `IDLE` → grant visible after edge N, i.e. 1 cycle.
- Release latency: owner `req` sampled low on edge N → `gnt` = 0 after edge N.
- Back-to-back hand-off: minimum 1 idle cycle with `gnt_valid`=0 between two owners.
- All outputs are registered; there are no combinational paths from `req` to any output.
- Simultaneous requests are resolved purely by `ptr`; no requester waits more than 3 other grants.
- A single persistent requester whose request stays high forever keeps the grant indefinitely when the timeout feature is compiled out.

## Configuration
- Macro `RR_ARB_HOLD_LIMIT_EN`.
- Defined:
  - In `BUSY`, when `hold_cnt` = `MAX_HOLD`-1 and the owner's request is still high, the next edge forces `IDLE`, clears the grant, and pulses `gnt_expired` for exactly one cycle.
  - `ptr` has already advanced past the owner. The evicted requester must keep its request high to re-enter arbitration; it is regranted only if no other requester is pending.
- Undefined:
  - Hold counter logic is absent.
  - `gnt_expired` is tied to 0.
  - Grants last until the owner releases.

## Test plan
- Reset check: assert `rst` for 2 cycles with `req`=1111 → `gnt`=0000, `gnt_idx`=00, `gnt_valid`=0, `gnt_expired`=0; release `rst` → first grant goes to requester 0 (`gnt`=0001, `gnt_idx`=00) one cycle later.
- Round-robin rotation: hold `req`=1111 and have each owner drop its request 3 cycles after being granted, then re-raise it. Required grant order is 0,1,2,3,0 with `gnt_idx` 00,01,10,11,00 and exactly one idle cycle between owners.
- Wrap-around: from reset, requester 3 alone (`req`=1000) → `gnt`=1000, `gnt_idx`=11. Release, then `req`=1001 → requester 0 wins (`ptr` wrapped to 0).
- Non-owner ignored: requester 2 owns the grant; requester 1 raises its request mid-grant → `gnt` stays 0100 until `req[2]` drops; then `gnt`=0010 after one idle cycle.
- Hold limit (macro defined, `MAX_HOLD`=8): `req`=0011 held constantly → requester 0 is granted for exactly 8 cycles, `gnt_expired` pulses once, one idle cycle follows, then `gnt`=0010. With the macro undefined, `gnt`=0001 persists for 50+ cycles and `gnt_expired` stays 0.
- Reset mid-operation: assert `rst` while `gnt`=0100 → outputs are zero on the next edge, and the next arbitration with `req`=1111 grants requester 0.

Source files
------------

// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_4
//  Description : Four-requester round-robin arbiter with registered one-hot
//                and encoded grant. A grant is held until its owner drops the
//                request. Optional hold-limit timer, compiled in with the
//                macro RR_ARB_HOLD_LIMIT_EN, revokes a grant after MAX_HOLD
//                cycles and pulses gnt_expired.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       gnt_expired
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_busy = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nxt;
    logic [3:0] r_gnt;
    logic [3:0] w_gnt_nxt;
    logic [1:0] r_gnt_idx;
    logic [1:0] w_gnt_idx_nxt;
    logic       r_gnt_valid;
    logic       w_gnt_valid_nxt;

    logic [1:0] w_win_idx;
    logic       w_win_found;

`ifdef RR_ARB_HOLD_LIMIT_EN
    logic [7:0] r_hold_cnt;
    logic [7:0] w_hold_cnt_nxt;
    logic       r_gnt_expired;
    logic       w_gnt_expired_nxt;
`endif

    // First asserted request scanning upward from the priority pointer.
    always_comb begin
        logic [1:0] cand;
        w_win_idx   = 2'd0;
        w_win_found = 1'b0;
        cand        = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = r_ptr + 2'(k);
            if (!w_win_found && req[cand]) begin
                w_win_idx   = cand;
                w_win_found = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; everything holds unless changed.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_gnt_nxt       = r_gnt;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_gnt_valid_nxt = r_gnt_valid;
`ifdef RR_ARB_HOLD_LIMIT_EN
        w_hold_cnt_nxt    = r_hold_cnt;
        w_gnt_expired_nxt = 1'b0;
`endif
        case (r_state)
            c_st_idle: begin
                if (w_win_found) begin
                    w_state_nxt     = c_st_busy;
                    w_gnt_nxt       = 4'(1 << w_win_idx);
                    w_gnt_idx_nxt   = w_win_idx;
                    w_gnt_valid_nxt = 1'b1;
                    w_ptr_nxt       = w_win_idx + 2'd1;
`ifdef RR_ARB_HOLD_LIMIT_EN
                    w_hold_cnt_nxt  = 8'd0;
`endif
                end
            end
            c_st_busy: begin
                // Release never re-arbitrates on the same edge, which
                // guarantees an idle cycle between consecutive owners.
                if (!req[r_gnt_idx]) begin
                    w_state_nxt     = c_st_idle;
                    w_gnt_nxt       = 4'b0000;
                    w_gnt_idx_nxt   = 2'd0;
                    w_gnt_valid_nxt = 1'b0;
                end
`ifdef RR_ARB_HOLD_LIMIT_EN
                else if (r_hold_cnt == 8'(MAX_HOLD - 1)) begin
                    w_state_nxt       = c_st_idle;
                    w_gnt_nxt         = 4'b0000;
                    w_gnt_idx_nxt     = 2'd0;
                    w_gnt_valid_nxt   = 1'b0;
                    w_gnt_expired_nxt = 1'b1;
                end
                else if (r_hold_cnt != 8'hFF) begin
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                end
`endif
            end
            default: begin
                w_state_nxt     = c_st_idle;
                w_gnt_nxt       = 4'b0000;
                w_gnt_idx_nxt   = 2'd0;
                w_gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_ptr       <= 2'd0;
            r_gnt       <= 4'b0000;
            r_gnt_idx   <= 2'd0;
            r_gnt_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
        end
    end

`ifdef RR_ARB_HOLD_LIMIT_EN
    // Hold counter and expiry pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt    <= 8'd0;
            r_gnt_expired <= 1'b0;
        end else begin
            r_hold_cnt    <= w_hold_cnt_nxt;
            r_gnt_expired <= w_gnt_expired_nxt;
        end
    end

    assign gnt_expired = r_gnt_expired;
`else
    // MAX_HOLD only matters when the hold limit is compiled in.
    logic w_unused_max_hold;
    assign w_unused_max_hold = (MAX_HOLD > 0);
    assign gnt_expired       = 1'b0;
`endif

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter_4
//  Description : Directed self-checking bench for rr_arbiter_4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       gnt_expired;

    int total = 0;
    int bad   = 0;

    rr_arbiter_4 #(.MAX_HOLD(8)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .gnt_valid   (gnt_valid),
        .gnt_expired (gnt_expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares {gnt_expired, gnt_valid, gnt_idx, gnt} as one word.
    task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                           input logic ev, input logic ee);
        chk(tag, {24'd0, gnt_expired, gnt_valid, gnt_idx, gnt}, {24'd0, ee, ev, ei, eg});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int order [5];
        int o;
        order = '{0, 1, 2, 3, 0};

        // Reset with all requesting
        rst = 1'b1;
        req = 4'b1111;
        tick();
        tick();
        chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("first_gnt", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Rotation: each owner holds 3 cycles, drops, re-raises
        for (int i = 0; i < 5; i++) begin
            o = order[i];
            for (int c = 0; c < 3; c++) begin
                chk_out($sformatf("rot%0d_c%0d", i, c), 4'(1 << o), o[1:0], 1'b1, 1'b0);
                if (c < 2) tick();
            end
            req[o] = 1'b0;
            tick();
            chk_out($sformatf("rot%0d_idle", i), 4'b0000, 2'd0, 1'b0, 1'b0);
            req[o] = 1'b1;
            tick();
        end
        chk_out("rot_next", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        chk_out("rot_end_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Wrap-around of the pointer from 3 to 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1000;
        tick();
        chk_out("wrap_r3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        chk_out("wrap_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b1001;
        tick();
        chk_out("wrap_r0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        tick();

        // Non-owner request ignored while busy (pointer now 1)
        req = 4'b0100;
        tick();
        chk_out("nonown_r2", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0110;
        tick();
        chk_out("nonown_hold1", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        chk_out("nonown_hold2", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0010;
        tick();
        chk_out("nonown_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_out("nonown_r1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        tick();

        // Persistent requester: hold limit or indefinite ownership
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0011;
        tick();
`ifdef RR_ARB_HOLD_LIMIT_EN
        for (int k = 1; k <= 8; k++) begin
            chk_out($sformatf("hold_c%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
            tick();
        end
        chk_out("hold_expired", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        chk_out("hold_next_r1", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
        for (int k = 1; k <= 60; k++) begin
            chk_out($sformatf("persist_c%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
            tick();
        end
`endif
        req = 4'b0000;
        tick();

        // Reset while requester 2 owns the grant
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0100;
        tick();
        chk_out("midrst_r2", 4'b0100, 2'd2, 1'b1, 1'b0);
        rst = 1'b1;
        req = 4'b1111;
        tick();
        chk_out("midrst_zero", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("midrst_r0", 4'b0001, 2'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
